// File: rtl/tcm_arbiter.sv
// tcm_arbiter: two-requester front end for the TCM memory block.
//
// The CPU instruction-fetch port (read-only, word accesses) and the data
// port (read/write, byte/word/long) share one TCM access per cycle. The
// data port wins by default; a starvation counter forces ifetch through
// after STARVE_MAX consecutive losses. Data accesses are turned into a
// word-aligned address plus big-endian byte enables with the write data
// replicated across lanes. Misaligned or reserved-size data requests are
// rejected with d_err and never reach the memory.
//
// Handshake: a requester raises *_req and holds its address and controls
// until it sees *_ack (or d_err for the data port) in the same cycle, which
// is combinational from the request. The TCM never stalls, so ack and
// memc_sel always coincide. Read data is returned exactly one cycle after
// the ack; *_rvalid is high in that cycle for the requester that issued the
// read, and *_q carries memr_q straight through in that cycle.
//
// The memory command/response bundles are flattened into memc_* / memr_q.
// dbg_owner and dbg_starve expose the two state registers.

module tcm_arbiter #(
    parameter int AW         = 15,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,

    // instruction-fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_a,
    output logic          if_ack,
    output logic          if_rvalid,
    output logic [31:0]   if_q,

    // data port
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_a,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic          d_rvalid,
    output logic [31:0]   d_q,

    // memory command (MemC)
    output logic          memc_sel,
    output logic          memc_wr,
    output logic [AW-1:0] memc_a,
    output logic [3:0]    memc_be,
    output logic [31:0]   memc_d,

    // memory response (MemR)
    input  logic [31:0]   memr_q,

    // state visibility
    output logic [1:0]    dbg_owner,
    output logic [3:0]    dbg_starve
);

    // pending-owner encoding for the read-return register
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    // access-size encoding on d_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]    owner_q;
    logic [1:0]    owner_d;
    logic [3:0]    starve_q;
    logic [3:0]    starve_d;

    logic          d_bad;
    logic          d_legal;
    logic          if_win;
    logic          d_win;

    logic [3:0]    d_be;
    logic [31:0]   d_lane_data;
    logic [AW-1:0] if_word_a;
    logic [AW-1:0] d_word_a;

    // ifetch ignores the byte offset entirely; it is only ever a word fetch
    logic          unused_if_offset;
    assign unused_if_offset = ^if_a[1:0];

    assign if_word_a = {if_a[AW-1:2], 2'b00};
    assign d_word_a  = {d_a[AW-1:2], 2'b00};

    // Legality of the data request: reserved size, or an offset that does
    // not match the natural alignment of the access size.
    always_comb begin
        d_bad = 1'b0;
        case (d_size)
            SZ_BYTE: d_bad = 1'b0;
            SZ_WORD: d_bad = d_a[0];
            SZ_LONG: d_bad = (d_a[1:0] != 2'b00);
            default: d_bad = 1'b1;
        endcase
    end

    assign d_err   = d_req & d_bad;
    assign d_legal = d_req & ~d_bad;

    // Arbitration: data by default; ifetch wins when data has nothing legal
    // to issue or when ifetch has lost STARVE_MAX times in a row. An
    // erroring data request does not count as competition.
    always_comb begin
        if_win = if_req & (~d_legal | (starve_q >= STARVE_LIM));
        d_win  = d_legal & ~if_win;
    end

    assign if_ack = if_win;
    assign d_ack  = d_win;

    // Big-endian lane generation: byte offset 0 lives in bits [31:24].
    // Write data is replicated so the enabled lane always sees the value.
    always_comb begin
        d_be        = 4'hF;
        d_lane_data = d_wdata;
        case (d_size)
            SZ_BYTE: begin
                d_be        = 4'b1000 >> d_a[1:0];
                d_lane_data = {4{d_wdata[7:0]}};
            end
            SZ_WORD: begin
                d_be        = d_a[1] ? 4'b0011 : 4'b1100;
                d_lane_data = {2{d_wdata[15:0]}};
            end
            default: begin
                d_be        = 4'hF;
                d_lane_data = d_wdata;
            end
        endcase
    end

    // Memory command mux: driven by whichever port won, quiet otherwise.
    always_comb begin
        memc_sel = 1'b0;
        memc_wr  = 1'b0;
        memc_a   = '0;
        memc_be  = 4'h0;
        memc_d   = 32'h0;
        if (if_win) begin
            memc_sel = 1'b1;
            memc_wr  = 1'b0;
            memc_a   = if_word_a;
            memc_be  = 4'hF;
            memc_d   = 32'h0;
        end else if (d_win) begin
            memc_sel = 1'b1;
            memc_wr  = d_wr;
            memc_a   = d_word_a;
            memc_be  = d_be;
            memc_d   = d_lane_data;
        end
    end

    // Next pending owner: only reads expect a response next cycle.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_win) begin
            owner_d = OWN_IF;
        end else if (d_win && !d_wr) begin
            owner_d = OWN_D;
        end
    end

    // Next starvation count: cleared whenever ifetch gets in, bumped when it
    // was asking and lost to a legal data request, held at the limit.
    always_comb begin
        starve_d = starve_q;
        if (if_win) begin
            starve_d = 4'd0;
        end else if (if_req && d_win && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Pending-owner register; an asynchronous reset drops any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Read return: one-cycle latency, routed to the issuing port only.
    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_q      = memr_q;
    assign d_q       = memr_q;

    assign dbg_owner  = owner_q;
    assign dbg_starve = starve_q;

endmodule

// File: tb/tb_tcm_arbiter.sv
// tb_tcm_arbiter: directed bench for tcm_arbiter (AW=15, STARVE_MAX=3).
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, registered effects of the previous rising edge are seen likewise.

module tb_tcm_arbiter;

    localparam int AW = 15;
    localparam int SM = 3;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_a;
    logic          if_ack;
    logic          if_rvalid;
    logic [31:0]   if_q;
    logic          d_req;
    logic          d_wr;
    logic [1:0]    d_size;
    logic [AW-1:0] d_a;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic          d_err;
    logic          d_rvalid;
    logic [31:0]   d_q;
    logic          memc_sel;
    logic          memc_wr;
    logic [AW-1:0] memc_a;
    logic [3:0]    memc_be;
    logic [31:0]   memc_d;
    logic [31:0]   memr_q;
    logic [1:0]    dbg_owner;
    logic [3:0]    dbg_starve;

    int vec_cnt = 0;
    int err_cnt = 0;

    // expected {if_rvalid, d_rvalid} for the cycle after each issue
    logic [1:0] exp_q[$];

    tcm_arbiter #(.AW(AW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_a(if_a), .if_ack(if_ack),
        .if_rvalid(if_rvalid), .if_q(if_q),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_a(d_a),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err),
        .d_rvalid(d_rvalid), .d_q(d_q),
        .memc_sel(memc_sel), .memc_wr(memc_wr), .memc_a(memc_a),
        .memc_be(memc_be), .memc_d(memc_d),
        .memr_q(memr_q),
        .dbg_owner(dbg_owner), .dbg_starve(dbg_starve)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks: each moves to the next falling edge, applies, settles
    task automatic drive_idle(input logic [31:0] q);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0;
        if_a = '0; d_a = '0; d_wdata = '0; memr_q = q;
        #1;
    endtask

    task automatic drive_if(input logic [AW-1:0] a, input logic [31:0] q);
        @(negedge clk);
        if_req = 1'b1; if_a = a; d_req = 1'b0; memr_q = q;
        #1;
    endtask

    task automatic drive_d(input logic wr, input logic [1:0] sz, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic [31:0] q);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b1; d_wr = wr; d_size = sz; d_a = a; d_wdata = wd; memr_q = q;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0;
        if_a = '0; d_a = '0; d_wdata = '0; memr_q = '0;
        repeat (2) @(negedge clk);
        #1;
        vec_cnt++; if (if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_if_rvalid got=%b exp=0", if_rvalid); end
        vec_cnt++; if (d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_d_rvalid got=%b exp=0", d_rvalid); end
        vec_cnt++; if (memc_sel !== 1'b0) begin err_cnt++; $display("FAIL rst_sel got=%b exp=0", memc_sel); end
        vec_cnt++; if ({if_ack, d_ack, d_err} !== 3'b000) begin err_cnt++; $display("FAIL rst_acks got=%b exp=000", {if_ack, d_ack, d_err}); end
        vec_cnt++; if (dbg_owner !== 2'd0) begin err_cnt++; $display("FAIL rst_owner got=%0d exp=0", dbg_owner); end
        vec_cnt++; if (dbg_starve !== 4'd0) begin err_cnt++; $display("FAIL rst_starve got=%0d exp=0", dbg_starve); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ifetch;
        drive_if(15'h0104, 32'h0);
        vec_cnt++; if ({memc_sel, memc_wr, if_ack, d_ack} !== 4'b1010) begin err_cnt++; $display("FAIL if_ctl got=%b exp=1010", {memc_sel, memc_wr, if_ack, d_ack}); end
        vec_cnt++; if (memc_a !== 15'h0104) begin err_cnt++; $display("FAIL if_a got=%h exp=0104", memc_a); end
        vec_cnt++; if (memc_be !== 4'hF) begin err_cnt++; $display("FAIL if_be got=%h exp=f", memc_be); end
        vec_cnt++; if (memc_d !== 32'h0) begin err_cnt++; $display("FAIL if_d got=%h exp=0", memc_d); end
        // second fetch with a non-zero offset; first read returns now
        drive_if(15'h0107, 32'hDEADBEEF);
        vec_cnt++; if ({if_rvalid, d_rvalid} !== 2'b10) begin err_cnt++; $display("FAIL if_rvalid1 got=%b exp=10", {if_rvalid, d_rvalid}); end
        vec_cnt++; if (if_q !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL if_q1 got=%h exp=deadbeef", if_q); end
        vec_cnt++; if (memc_a !== 15'h0104) begin err_cnt++; $display("FAIL if_a_mask got=%h exp=0104", memc_a); end
        drive_idle(32'hCAFEF00D);
        vec_cnt++; if ({if_rvalid, d_rvalid, memc_sel} !== 3'b100) begin err_cnt++; $display("FAIL if_rvalid2 got=%b exp=100", {if_rvalid, d_rvalid, memc_sel}); end
        vec_cnt++; if (if_q !== 32'hCAFEF00D) begin err_cnt++; $display("FAIL if_q2 got=%h exp=cafef00d", if_q); end
        drive_idle(32'h0);
        vec_cnt++; if ({if_rvalid, d_rvalid} !== 2'b00) begin err_cnt++; $display("FAIL if_idle_rvalid got=%b exp=00", {if_rvalid, d_rvalid}); end
    endtask

    task automatic test_byte_write;
        drive_d(1'b1, 2'd0, 15'h0013, 32'h000000A5, 32'h0);
        vec_cnt++; if ({memc_sel, memc_wr, d_ack, d_err, if_ack} !== 5'b11100) begin err_cnt++; $display("FAIL bw_ctl got=%b exp=11100", {memc_sel, memc_wr, d_ack, d_err, if_ack}); end
        vec_cnt++; if (memc_a !== 15'h0010) begin err_cnt++; $display("FAIL bw_a got=%h exp=0010", memc_a); end
        vec_cnt++; if (memc_be !== 4'b0001) begin err_cnt++; $display("FAIL bw_be got=%b exp=0001", memc_be); end
        vec_cnt++; if (memc_d !== 32'hA5A5A5A5) begin err_cnt++; $display("FAIL bw_d got=%h exp=a5a5a5a5", memc_d); end
        drive_d(1'b1, 2'd0, 15'h0011, 32'hFFFFFF3C, 32'h0);
        vec_cnt++; if ({if_rvalid, d_rvalid} !== 2'b00) begin err_cnt++; $display("FAIL bw_norvalid got=%b exp=00", {if_rvalid, d_rvalid}); end
        vec_cnt++; if (memc_be !== 4'b0100) begin err_cnt++; $display("FAIL bw_be1 got=%b exp=0100", memc_be); end
        vec_cnt++; if (memc_d !== 32'h3C3C3C3C) begin err_cnt++; $display("FAIL bw_d1 got=%h exp=3c3c3c3c", memc_d); end
        drive_d(1'b0, 2'd0, 15'h0014, 32'h0, 32'h0);
        vec_cnt++; if ({memc_be, memc_wr} !== 5'b10000) begin err_cnt++; $display("FAIL br_be0 got=%b exp=10000", {memc_be, memc_wr}); end
        drive_idle(32'h55AA0FF0);
        vec_cnt++; if ({if_rvalid, d_rvalid} !== 2'b01) begin err_cnt++; $display("FAIL br_rvalid got=%b exp=01", {if_rvalid, d_rvalid}); end
        vec_cnt++; if (d_q !== 32'h55AA0FF0) begin err_cnt++; $display("FAIL br_q got=%h exp=55aa0ff0", d_q); end
    endtask

    task automatic test_word;
        drive_d(1'b1, 2'd1, 15'h0022, 32'h00001234, 32'h0);
        vec_cnt++; if ({memc_sel, memc_wr, d_ack, d_err} !== 4'b1110) begin err_cnt++; $display("FAIL ww_ctl got=%b exp=1110", {memc_sel, memc_wr, d_ack, d_err}); end
        vec_cnt++; if ({memc_a, memc_be} !== {15'h0020, 4'b0011}) begin err_cnt++; $display("FAIL ww_a_be got=%h/%b exp=0020/0011", memc_a, memc_be); end
        vec_cnt++; if (memc_d !== 32'h12341234) begin err_cnt++; $display("FAIL ww_d got=%h exp=12341234", memc_d); end
        drive_d(1'b0, 2'd1, 15'h0021, 32'h0, 32'h0);
        vec_cnt++; if ({d_err, d_ack, memc_sel} !== 3'b100) begin err_cnt++; $display("FAIL wr_mis got=%b exp=100", {d_err, d_ack, memc_sel}); end
        drive_d(1'b0, 2'd1, 15'h0020, 32'h0, 32'h0);
        vec_cnt++; if ({d_rvalid, if_rvalid} !== 2'b00) begin err_cnt++; $display("FAIL wr_mis_rvalid got=%b exp=00", {d_rvalid, if_rvalid}); end
        vec_cnt++; if ({d_ack, memc_wr, memc_be} !== 6'b101100) begin err_cnt++; $display("FAIL wr_be got=%b exp=101100", {d_ack, memc_wr, memc_be}); end
        drive_idle(32'h0BADC0DE);
        vec_cnt++; if ({d_rvalid, d_q} !== {1'b1, 32'h0BADC0DE}) begin err_cnt++; $display("FAIL wr_ret got=%b/%h exp=1/0badc0de", d_rvalid, d_q); end
    endtask

    task automatic test_long;
        drive_d(1'b1, 2'd2, 15'h0040, 32'h11223344, 32'h0);
        vec_cnt++; if ({memc_be, memc_d} !== {4'hF, 32'h11223344}) begin err_cnt++; $display("FAIL lw_be_d got=%h/%h exp=f/11223344", memc_be, memc_d); end
        drive_d(1'b0, 2'd2, 15'h0042, 32'h0, 32'h0);
        vec_cnt++; if ({d_err, d_ack, memc_sel} !== 3'b100) begin err_cnt++; $display("FAIL lr_mis got=%b exp=100", {d_err, d_ack, memc_sel}); end
        drive_d(1'b0, 2'd3, 15'h0040, 32'h0, 32'h0);
        vec_cnt++; if ({d_err, d_ack, memc_sel} !== 3'b100) begin err_cnt++; $display("FAIL rsv_size got=%b exp=100", {d_err, d_ack, memc_sel}); end
        // an erroring data request must not block or starve ifetch
        @(negedge clk);
        if_req = 1'b1; if_a = 15'h0300; #1;
        vec_cnt++; if ({if_ack, d_ack, d_err, memc_a} !== {3'b101, 15'h0300}) begin err_cnt++; $display("FAIL err_if got=%b/%h exp=101/0300", {if_ack, d_ack, d_err}, memc_a); end
        drive_idle(32'h0);
        vec_cnt++; if ({dbg_starve, if_rvalid} !== 5'b00001) begin err_cnt++; $display("FAIL err_if_state got=%h/%b exp=0/1", dbg_starve, if_rvalid); end
    endtask

    task automatic test_contention;
        logic [1:0] w;
        logic [1:0] e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if_req = 1'b1; if_a = 15'h0200;
            d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_a = 15'h0300;
            memr_q = 32'hA0000000 + i;
            #1;
            w = (i == 3) ? 2'b10 : 2'b01;
            vec_cnt++; if (dbg_starve !== ((i <= 3) ? 4'(i) : 4'(i - 4))) begin err_cnt++; $display("FAIL ct_starve%0d got=%0d", i, dbg_starve); end
            vec_cnt++; if ({if_ack, d_ack} !== w) begin err_cnt++; $display("FAIL ct_ack%0d got=%b exp=%b", i, {if_ack, d_ack}, w); end
            vec_cnt++; if (memc_a !== ((i == 3) ? 15'h0200 : 15'h0300)) begin err_cnt++; $display("FAIL ct_a%0d got=%h", i, memc_a); end
            if (i > 0) begin
                e = exp_q.pop_front();
                vec_cnt++; if ({if_rvalid, d_rvalid} !== e) begin err_cnt++; $display("FAIL ct_rvalid%0d got=%b exp=%b", i, {if_rvalid, d_rvalid}, e); end
            end
            exp_q.push_back(w);
        end
        drive_idle(32'h0);
        e = exp_q.pop_front();
        vec_cnt++; if ({if_rvalid, d_rvalid} !== e) begin err_cnt++; $display("FAIL ct_rvalid_last got=%b exp=%b", {if_rvalid, d_rvalid}, e); end
    endtask

    task automatic test_back_to_back;
        drive_d(1'b0, 2'd2, 15'h0080, 32'h0, 32'h0);
        vec_cnt++; if ({d_ack, if_rvalid, d_rvalid} !== 3'b100) begin err_cnt++; $display("FAIL b2b_c1 got=%b exp=100", {d_ack, if_rvalid, d_rvalid}); end
        drive_if(15'h0090, 32'h01010101);
        vec_cnt++; if ({if_ack, memc_sel, if_rvalid, d_rvalid} !== 4'b1101) begin err_cnt++; $display("FAIL b2b_c2 got=%b exp=1101", {if_ack, memc_sel, if_rvalid, d_rvalid}); end
        vec_cnt++; if (d_q !== 32'h01010101) begin err_cnt++; $display("FAIL b2b_dq got=%h exp=01010101", d_q); end
        drive_idle(32'h02020202);
        vec_cnt++; if ({if_rvalid, d_rvalid} !== 2'b10) begin err_cnt++; $display("FAIL b2b_c3 got=%b exp=10", {if_rvalid, d_rvalid}); end
        vec_cnt++; if (if_q !== 32'h02020202) begin err_cnt++; $display("FAIL b2b_ifq got=%h exp=02020202", if_q); end
    endtask

    task automatic test_reset_mid;
        drive_d(1'b0, 2'd2, 15'h00C0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk); #1;
        vec_cnt++; if ({d_rvalid, if_rvalid, dbg_owner} !== 4'b0000) begin err_cnt++; $display("FAIL rm_drop got=%b exp=0000", {d_rvalid, if_rvalid, dbg_owner}); end
        rst_n = 1'b1;
        drive_idle(32'h0);
        vec_cnt++; if ({memc_sel, if_rvalid, d_rvalid} !== 3'b000) begin err_cnt++; $display("FAIL rm_after got=%b exp=000", {memc_sel, if_rvalid, d_rvalid}); end
    endtask

    initial begin
        test_reset;
        test_ifetch;
        test_byte_write;
        test_word;
        test_long;
        test_contention;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/tcm_arbiter.md
Name: tcm_arbiter

Overview:
Two-requester front end for the TCM `memory` block. It arbitrates between the CPU instruction-fetch port (read-only) and the data port (read/write) and drives a single MemC. It also routes MemR.q back to whichever requester issued the read. The data port presents byte addresses with an access size; the block generates big-endian byte enables, replicates write data across lanes, and rejects misaligned accesses.

Parameters:
AW, 15, TCM byte-address width; must match the downstream memory's AW.
STARVE_MAX, 3, max consecutive cycles an ifetch request may lose to data before it is forced to win (1..15).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
if_req  input  1  ifetch request, held until if_ack
if_a  input  AW  ifetch byte address (word access; a[1:0] ignored)
if_ack  output  1  ifetch request accepted this cycle (combinational)
if_rvalid  output  1  ifetch read data valid
if_q  output  32  ifetch read data
d_req  input  1  data request, held until d_ack or d_err
d_wr  input  1  1=write, 0=read
d_size  input  2  0=byte, 1=word(16b), 2=long(32b), 3=reserved
d_a  input  AW  data byte address
d_wdata  input  32  write data, right-justified (byte in [7:0], word in [15:0])
d_ack  output  1  data request accepted this cycle (combinational)
d_err  output  1  misaligned/reserved-size request rejected (combinational)
d_rvalid  output  1  data read data valid
d_q  output  32  data read data (full 32-bit word; CPU extracts lane)
memc  output  MemC  to memory: sel, wr, a, be, d
memr  input  MemR  from memory: q

Behaviour:
- Reset: if_rvalid=0, d_rvalid=0, starve count=0, pending-owner register=NONE. Combinational outputs (if_ack, d_ack, d_err, memc.*) follow their equations; with no requests memc.sel=0.
- Legality: d_err=d_req & (size==3 | (size==1 & a[0]) | (size==2 & a[1:0]!=0)). An erroring request is never issued; d_ack=0; the requester must drop it. d_err does not consume arbitration.
- Arbitration (every cycle, combinational): d_legal=d_req&~d_err. The data port wins by default. Ifetch wins if ~d_legal, or if starve count>=STARVE_MAX.
- Starve counter: increments when if_req & d_legal and data wins; clears when if_ack; saturates at STARVE_MAX.
- Issue: winner's ack=1 and memc.sel=1 in the same cycle. There is no back-pressure from memory; the TCM accepts one access per cycle.
- Ifetch issue: wr=0, be=4'hF, a={if_a[AW-1:2],2'b00}, d=0.
- Data issue: a={d_a[AW-1:2],2'b00}, wr=d_wr, big-endian lanes (offset 0 = bits[31:24]):
  - byte: be=4'b1000>>a[1:0]; d={4{wdata[7:0]}}
  - word: be=a[1]?4'b0011:4'b1100; d={2{wdata[15:0]}}
  - long: be=4'hF; d=wdata
  - Reads use the same be (the memory ignores it).
- Read return: latency is exactly 1 cycle.
  - At issue of a read, the pending-owner register captures IF or D; writes and idle cycles capture NONE.
  - The next cycle, if_rvalid/d_rvalid=1 for the owner only.
  - if_q=d_q=memr.q, passed through without registering.
- Back-to-back: a new access may issue in the same cycle that the previous read's rvalid is high; full throughput is 1 access/cycle.
- Simultaneous if_req and d_req: exactly one ack per cycle; the loser holds its request and retries.
- Reset mid-operation: the pending-owner register clears asynchronously; a read issued in the cycle before reset returns no rvalid.
- The address bits above AW do not exist on the ports; wrap is the caller's concern.

Test Plan:
- Ifetch only: if_req, if_a=0x0104 -> memc.sel=1, a=0x0104, be=F, wr=0, if_ack=1; next cycle if_rvalid=1, d_rvalid=0, if_q=memr.q.
- Byte write: d_wr=1, size=0, a=0x0013, wdata=0x000000A5 -> memc.a=0x0010, be=4'b0001, d=0xA5A5A5A5, d_ack=1, no rvalid.
- Word write to a=0x0022, wdata=0x1234 -> be=4'b0011, d=0x12341234. Word read at a=0x0021 -> d_err=1, d_ack=0, memc.sel=0.
- Contention, STARVE_MAX=3: if_req and d_req (legal reads) held continuously -> d_ack for 3 cycles, if_ack on cycle 4, counter clears, data resumes cycle 5; rvalids track owners with 1-cycle lag.
- Back-to-back D read then IF read in consecutive cycles -> d_rvalid in cycle 2, if_rvalid in cycle 3, never both high in one cycle.
- Assert rst_n low the cycle after a D read issue -> d_rvalid stays 0; after release with no requests, memc.sel=0 and all rvalids=0.
